lbm_window_gen: RTL and testbench

- Downstream neighbour of the 3-row lattice line buffer (3*SCREEN_WIDTH-deep shift register with row taps tap0/tap1/tap2).
- Consumes the three row taps on every buffer shift strobe and builds a registered 3x3 (D2Q9) neighbourhood around each lattice cell in raster order.
- Substitutes out-of-grid neighbours at the lattice boundary and reports cell coordinates for the collide/stream stage.
- Sequences one frame per start pulse and tells the upstream feeder when to push padding strobes.

---
 rtl/lbm_window_gen.sv | 153 +++++++++++++++
 tb/tb_lbm_window_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lbm_window_gen.sv
// lbm_window_gen: builds registered D2Q9 3x3 windows from line-buffer row taps; define LBM_WINDOW_ZERO_PAD_EN for zero padding instead of bounce-back
module lbm_window_gen #(
    parameter int SCREEN_WIDTH  = 8,
    parameter int SCREEN_HEIGHT = 8,
    parameter int N_BITS        = 15
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_frame_start,
    input  logic                             i_shift_n,
    input  logic [N_BITS-1:0]                i_tap0_in,
    input  logic [N_BITS-1:0]                i_tap1_in,
    input  logic [N_BITS-1:0]                i_tap2_in,
    output logic                             o_need_pad,
    output logic                             o_busy,
    output logic                             o_out_valid,
    output logic [9*N_BITS-1:0]              o_window,
    output logic [$clog2(SCREEN_WIDTH)-1:0]  o_cx,
    output logic [$clog2(SCREEN_HEIGHT)-1:0] o_cy,
    output logic [3:0]                       o_edge,
    output logic                             o_frame_done
);
    localparam int W    = SCREEN_WIDTH;
    localparam int H    = SCREEN_HEIGHT;
    localparam int LAST = W * H + 2 * W;
    localparam int SW   = $clog2(LAST + 2);
    localparam int CXW  = $clog2(W);
    localparam int CYW  = $clog2(H);
    localparam logic [SW-1:0]  S_FIRST = SW'(2 * W + 1);
    localparam logic [SW-1:0]  S_PAD   = SW'(W * H);
    localparam logic [SW-1:0]  S_LAST  = SW'(LAST);
    localparam logic [CXW-1:0] CX_MAX  = CXW'(W - 1);
    localparam logic [CYW-1:0] CY_MAX  = CYW'(H - 1);

    typedef enum logic [2:0] {IDLE, PRIME, RUN, PAD, DONE} state_t;

    state_t            r_state;
    logic [SW-1:0]     r_s;
    logic [CXW-1:0]    r_ccx;
    logic [CYW-1:0]    r_ccy;
    logic [N_BITS-1:0] r_cm [3];
    logic [N_BITS-1:0] r_cr [3];
    logic [N_BITS-1:0] w_tap [3];
    logic [N_BITS-1:0] w_sl [9];
    logic [N_BITS-1:0] w_sub;
    logic [9*N_BITS-1:0] w_win;
    logic [SW-1:0]     w_s_nx;
    logic              w_stb, w_emit, w_n, w_s, w_w, w_e;

    assign w_tap[0] = i_tap0_in;
    assign w_tap[1] = i_tap1_in;
    assign w_tap[2] = i_tap2_in;
    assign w_stb    = ~i_shift_n & (r_state == PRIME || r_state == RUN || r_state == PAD);
    assign w_emit   = w_stb & (r_s >= S_FIRST);
    assign w_s_nx   = r_s + 1'b1;
    assign w_n      = r_ccy == '0;
    assign w_s      = r_ccy == CY_MAX;
    assign w_w      = r_ccx == '0;
    assign w_e      = r_ccx == CX_MAX;
`ifdef LBM_WINDOW_ZERO_PAD_EN
    assign w_sub    = '0;
`else
    assign w_sub    = r_cr[1];
`endif
    assign w_win    = {w_sl[8], w_sl[7], w_sl[6], w_sl[5], w_sl[4], w_sl[3], w_sl[2], w_sl[1], w_sl[0]};

    // left column = previous centre reg, centre = previous right reg, right = live taps; out-of-grid slices substituted
    always_comb begin
        w_sl[0] = (w_n | w_w) ? w_sub : r_cm[0];
        w_sl[1] = w_n ? w_sub : r_cr[0];
        w_sl[2] = (w_n | w_e) ? w_sub : i_tap0_in;
        w_sl[3] = w_w ? w_sub : r_cm[1];
        w_sl[4] = r_cr[1];
        w_sl[5] = w_e ? w_sub : i_tap1_in;
        w_sl[6] = (w_s | w_w) ? w_sub : r_cm[2];
        w_sl[7] = w_s ? w_sub : r_cr[2];
        w_sl[8] = (w_s | w_e) ? w_sub : i_tap2_in;
    end

    // frame sequencer, column shift, centre coordinate counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_s          <= '0;
            r_ccx        <= '0;
            r_ccy        <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cm[i] <= '0;
                r_cr[i] <= '0;
            end
            o_need_pad   <= 1'b0;
            o_busy       <= 1'b0;
            o_out_valid  <= 1'b0;
            o_window     <= '0;
            o_cx         <= '0;
            o_cy         <= '0;
            o_edge       <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_out_valid  <= 1'b0;
            o_frame_done <= 1'b0;
            if (w_stb) begin
                for (int i = 0; i < 3; i++) begin
                    r_cm[i] <= r_cr[i];
                    r_cr[i] <= w_tap[i];
                end
                r_s <= w_s_nx;
            end
            if (w_emit) begin
                o_out_valid <= 1'b1;
                o_window    <= w_win;
                o_cx        <= r_ccx;
                o_cy        <= r_ccy;
                o_edge      <= {w_n, w_s, w_w, w_e};
                r_ccx       <= w_e ? '0 : r_ccx + 1'b1;
                if (w_e)
                    r_ccy <= w_s ? '0 : r_ccy + 1'b1;
            end
            case (r_state)
                IDLE, DONE: begin
                    if (i_frame_start) begin
                        r_state <= PRIME;
                        r_s     <= '0;
                        r_ccx   <= '0;
                        r_ccy   <= '0;
                        o_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                PRIME, RUN: begin
                    if (w_stb) begin
                        if (w_s_nx >= S_PAD) begin
                            r_state    <= PAD;
                            o_need_pad <= 1'b1;
                        end else if (w_s_nx >= S_FIRST) begin
                            r_state <= RUN;
                        end
                    end
                end
                PAD: begin
                    if (w_stb && r_s == S_LAST) begin
                        r_state      <= DONE;
                        o_need_pad   <= 1'b0;
                        o_busy       <= 1'b0;
                        o_frame_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lbm_window_gen.sv
// tb_lbm_window_gen: line-buffer model feeding lbm_window_gen, checked against a grid-level neighbourhood model
module tb_lbm_window_gen;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int N    = 15;
    localparam int WH   = W * H;
    localparam int LAST = WH + 2 * W;
    localparam int WB   = 9 * N;
`ifdef LBM_WINDOW_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    typedef struct {
        int             c;
        logic [WB-1:0]  win;
        logic [2:0]     x;
        logic [2:0]     y;
        logic [3:0]     e;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic frame_start = 1'b0;
    logic shift_n = 1'b1;
    logic [N-1:0] tap0, tap1, tap2;
    logic need_pad, busy, out_valid, frame_done;
    logic [WB-1:0] window;
    logic [2:0] cx, cy;
    logic [3:0] edg;

    int total = 0;
    int bad = 0;
    logic [N-1:0]  lb [3*W];
    logic [N-1:0]  grid [WH];
    logic [WB-1:0] cap_win [WH];
    logic [2:0]    cap_cx [WH];
    logic [2:0]    cap_cy [WH];
    logic [3:0]    cap_edge [WH];
    vec_t          tbl [5];

    lbm_window_gen #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .N_BITS(N)) dut (
        .clk(clk), .reset(reset), .i_frame_start(frame_start), .i_shift_n(shift_n),
        .i_tap0_in(tap0), .i_tap1_in(tap1), .i_tap2_in(tap2),
        .o_need_pad(need_pad), .o_busy(busy), .o_out_valid(out_valid), .o_window(window),
        .o_cx(cx), .o_cy(cy), .o_edge(edg), .o_frame_done(frame_done)
    );

    always #5 clk = ~clk;

    assign tap2 = lb[W-1];
    assign tap1 = lb[2*W-1];
    assign tap0 = lb[3*W-1];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [WB-1:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {N'(a8), N'(a7), N'(a6), N'(a5), N'(a4), N'(a3), N'(a2), N'(a1), N'(a0)};
    endfunction

    function automatic logic [WB-1:0] model_win(input int c);
        logic [WB-1:0] r;
        int x, y;
        r = '0;
        for (int k = 0; k < 9; k++) begin
            x = c % W + k % 3 - 1;
            y = c / W + k / 3 - 1;
            if (x < 0 || x >= W || y < 0 || y >= H)
                r[k*N +: N] = ZP ? '0 : grid[c];
            else
                r[k*N +: N] = grid[y*W + x];
        end
        return r;
    endfunction

    task automatic lb_push(input logic [N-1:0] d);
        for (int i = 3*W-1; i > 0; i--) lb[i] = lb[i-1];
        lb[0] = d;
    endtask

    task automatic do_frame(input bit dir, input int gap_max, input int abort_at, input bit midstart);
        int nv;
        int c;
        logic [N-1:0] d;
        nv = 0;
        for (int i = 0; i < WH; i++) grid[i] = dir ? N'(i) : N'($urandom);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("busy_after_start", busy, 1);
        for (int s = 0; s <= LAST; s++) begin
            for (int g = (gap_max > 0 ? int'($urandom_range(gap_max, 0)) : 0); g > 0; g--) begin
                shift_n = 1'b1;
                @(posedge clk); #1;
                chk("gap_no_valid", out_valid, 0);
            end
            d = s < WH ? grid[s] : N'($urandom);
            shift_n = 1'b0;
            frame_start = midstart && s == 30;
            @(posedge clk); #1;
            lb_push(d);
            shift_n = 1'b1;
            frame_start = 1'b0;
            c = s - 2*W - 1;
            chk("valid_timing", out_valid, c >= 0);
            if (c >= 0 && out_valid) begin
                nv++;
                chk("window", window, model_win(c));
                chk("cx", cx, c % W);
                chk("cy", cy, c / W);
                chk("edge", edg, {c / W == 0, c / W == H-1, c % W == 0, c % W == W-1});
                if (dir) begin
                    cap_win[c]  = window;
                    cap_cx[c]   = cx;
                    cap_cy[c]   = cy;
                    cap_edge[c] = edg;
                end
            end
            chk("frame_done", frame_done, s == LAST);
            chk("need_pad", need_pad, s + 1 >= WH && s != LAST);
            chk("busy", busy, s != LAST);
            if (s + 1 == abort_at) begin
                reset = 1'b0;
                #1;
                chk("reset_clears", {need_pad, busy, out_valid, frame_done, window, cx, cy, edg}, 0);
                @(posedge clk); #1;
                reset = 1'b1;
                return;
            end
        end
        chk("valid_count", nv, WH);
        @(posedge clk); #1;
        chk("done_clear", {out_valid, frame_done, busy, need_pad}, 0);
    endtask

    initial begin
        tbl[0] = '{0,  w9(0, 0, 0, 0, 0, 1, 0, 8, 9), 3'd0, 3'd0, 4'b1010};
        tbl[1] = '{7,  ZP ? w9(0, 0, 0, 6, 7, 0, 14, 15, 0) : w9(7, 7, 7, 6, 7, 7, 14, 15, 7), 3'd7, 3'd0, 4'b1001};
        tbl[2] = '{27, w9(18, 19, 20, 26, 27, 28, 34, 35, 36), 3'd3, 3'd3, 4'b0000};
        tbl[3] = '{56, ZP ? w9(0, 48, 49, 0, 56, 57, 0, 0, 0) : w9(56, 48, 49, 56, 56, 57, 56, 56, 56), 3'd0, 3'd7, 4'b0110};
        tbl[4] = '{63, ZP ? w9(54, 55, 0, 62, 63, 0, 0, 0, 0) : w9(54, 55, 63, 62, 63, 63, 63, 63, 63), 3'd7, 3'd7, 4'b0101};
        for (int i = 0; i < 3*W; i++) lb[i] = N'($urandom);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {need_pad, busy, out_valid, frame_done, window, cx, cy, edg}, 0);
        reset = 1'b1;
        shift_n = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("idle_strobe", {out_valid, busy, need_pad, frame_done}, 0);
        end
        shift_n = 1'b1;
        do_frame(1'b1, 0, 0, 1'b1);
        for (int v = 0; v < 5; v++) begin
            chk("tbl_window", cap_win[tbl[v].c], tbl[v].win);
            chk("tbl_cx", cap_cx[tbl[v].c], tbl[v].x);
            chk("tbl_cy", cap_cy[tbl[v].c], tbl[v].y);
            chk("tbl_edge", cap_edge[tbl[v].c], tbl[v].e);
        end
        do_frame(1'b0, 5, 0, 1'b0);
        do_frame(1'b0, 2, 40, 1'b0);
        do_frame(1'b0, 0, 0, 1'b0);
        do_frame(1'b1, 3, 0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
